// File: rtl/rider_detect_if.sv
// rider_detect_if: groups the load-cell inputs and the qualifier outputs of
// rider_detect into one bundle. The sampler/testbench side uses the master
// modport, the qualifier itself uses the slave modport.
`default_nettype none

interface rider_detect_if #(
    parameter int LD_W = 12
);
    // Raw signed load-cell samples from the sampler.
    logic signed [LD_W-1:0] lft_ld;
    logic signed [LD_W-1:0] rght_ld;

    // Qualifier results handed on to balance_cntrl.
    logic signed [LD_W:0]   ld_cell_diff;
    logic                   en_steer;
    logic                   rider_off;
    logic [1:0]             rider_state;

    modport master (
        output lft_ld,
        output rght_ld,
        input  ld_cell_diff,
        input  en_steer,
        input  rider_off,
        input  rider_state
    );

    modport slave (
        input  lft_ld,
        input  rght_ld,
        output ld_cell_diff,
        output en_steer,
        output rider_off,
        output rider_state
    );
endinterface

`default_nettype wire

// File: rtl/rider_detect.sv
// rider_detect: rider-presence and balance qualifier for the Segway control
// path. Sums and differences the left/right load cells, applies a min-weight
// threshold, and requires the rider to stay centred for a full dwell period
// before raising en_steer. A registered one-cycle rider_off pulse marks a
// steering rider stepping off the platform.
//
// Build option: define RIDER_HYST_EN to use a hysteresis band of +/-HYST
// around MIN_WEIGHT. Without it a single threshold at MIN_WEIGHT is used and
// HYST is ignored.
`default_nettype none

module rider_detect #(
    parameter int              LD_W       = 12,
    parameter int              TMR_W      = 26,
    parameter logic [LD_W-1:0] MIN_WEIGHT = 12'h200,
    parameter logic [LD_W-1:0] HYST       = 12'h040
) (
    input  logic           clk,
    input  logic           rst,
    rider_detect_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    // Weight threshold widened to the arithmetic width; it is a positive
    // quantity, so it is zero-extended.
    localparam logic signed [LD_W:0] MIN_EXT = {1'b0, MIN_WEIGHT};

`ifdef RIDER_HYST_EN
    localparam logic signed [LD_W:0] HYST_EXT  = {1'b0, HYST};
    localparam logic signed [LD_W:0] UPPER_THR = MIN_EXT + HYST_EXT;
    localparam logic signed [LD_W:0] LOWER_THR = MIN_EXT - HYST_EXT;
`endif

    logic signed [LD_W:0] lft_ext;
    logic signed [LD_W:0] rght_ext;
    logic signed [LD_W:0] sum;
    logic signed [LD_W:0] diff;
    logic        [LD_W:0] abs_diff;
    logic signed [LD_W:0] q_thr;
    logic signed [LD_W:0] s_thr;

    logic sum_gt_min;
    logic sum_lt_min;
    logic diff_gt_q;
    logic diff_gt_s;

    state_t           state;
    state_t           next_state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] next_timer;
    logic             rider_off_q;
    logic             rider_off_next;
    logic             timer_full;

    // Sign-extend both cells by one bit so sum and difference can never overflow.
    always_comb begin
        lft_ext  = {bus.lft_ld[LD_W-1], bus.lft_ld};
        rght_ext = {bus.rght_ld[LD_W-1], bus.rght_ld};
        sum      = lft_ext + rght_ext;
        diff     = lft_ext - rght_ext;
        abs_diff = diff[LD_W] ? $unsigned(-diff) : $unsigned(diff);
    end

    // Balance limits scale with total weight: a quarter of the sum while
    // qualifying, and a looser 15/16 of the sum once steering.
    always_comb begin
        q_thr = sum >>> 2;
        s_thr = sum - (sum >>> 4);
    end

    // A negative threshold (negative sum) is always exceeded by the magnitude;
    // otherwise an unsigned magnitude compare is exact.
    always_comb begin
        diff_gt_q = q_thr[LD_W] | (abs_diff > $unsigned(q_thr));
        diff_gt_s = s_thr[LD_W] | (abs_diff > $unsigned(s_thr));
    end

`ifdef RIDER_HYST_EN
    // Separate on/off thresholds so a rider near MIN_WEIGHT does not chatter.
    always_comb begin
        sum_gt_min = (sum > UPPER_THR);
        sum_lt_min = (sum < LOWER_THR);
    end
`else
    // Single threshold: presence and absence are exact complements.
    always_comb begin
        sum_gt_min = (sum >= MIN_EXT);
        sum_lt_min = !sum_gt_min;
    end
`endif

    assign timer_full = &timer;

    // State, dwell timer and the rider_off pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            rider_off_q <= 1'b0;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            rider_off_q <= rider_off_next;
        end
    end

    // Next-state and timer logic; leaving the platform outranks imbalance,
    // which in turn outranks dwell completion.
    always_comb begin
        next_state     = state;
        next_timer     = timer;
        rider_off_next = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    next_state = WAIT;
                    next_timer = '0;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    next_state = IDLE;
                end else if (diff_gt_q) begin
                    next_timer = '0;
                end else if (timer_full) begin
                    next_state = STEER_EN;
                end else begin
                    next_timer = timer + 1'b1;
                end
            end
            STEER_EN: begin
                if (sum_lt_min) begin
                    next_state     = IDLE;
                    rider_off_next = 1'b1;
                end else if (diff_gt_s) begin
                    next_state = WAIT;
                    next_timer = '0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore outputs; an illegal encoding reports as IDLE with everything low.
    always_comb begin
        bus.en_steer     = (state == STEER_EN);
        bus.rider_off    = rider_off_q;
        bus.rider_state  = (state == ILLEGAL) ? IDLE : state;
        bus.ld_cell_diff = diff;
    end

endmodule

`default_nettype wire

// File: doc/rider_detect.md
# rider_detect

Parametrised rider-presence and balance qualifier for the Segway control path. Sits between the load-cell sampler and `balance_cntrl`. It sums and differences the left/right load-cell readings and applies min-weight hysteresis. It qualifies the rider as centred for a programmable dwell time, then raises `en_steer`; it pulses `rider_off` when a steering rider leaves the platform.

## Interface
Parameters:
- `LD_W`, 12: load-cell sample width (signed).
- `TMR_W`, 26: dwell-timer width; dwell is 2^TMR_W−1 cycles (≈1.34 s at 50 MHz).
- `MIN_WEIGHT`, 12'h200: nominal min rider weight, `LD_W` bits.
- `HYST`, 12'h040: hysteresis half-band, `LD_W` bits; requires HYST < MIN_WEIGHT.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `lft_ld`  in  LD_W  signed left load cell.
- `rght_ld`  in  LD_W  signed right load cell.
- `ld_cell_diff`  out  LD_W+1  signed lft_ld−rght_ld (combinational).
- `en_steer`  out  1  steering enable, Moore, high in STEER_EN.
- `rider_off`  out  1  one-cycle registered pulse on STEER_EN→IDLE.
- `rider_state`  out  2  current state encoding: IDLE=0, WAIT=1, STEER_EN=2.

## Operation
- Arithmetic uses LD_W+1 signed bits throughout:
  - sum = lft+rght.
  - diff = lft−rght.
  - abs = |diff|, unsigned LD_W+1.
- Thresholds:
  - q = sum>>>2 (arithmetic).
  - s = sum − (sum>>>4).
  - Negative sum yields negative thresholds, so abs always exceeds them.
- Comparison flags:
  - sum_gt_min = sum > MIN_WEIGHT+HYST.
  - sum_lt_min = sum < MIN_WEIGHT−HYST.
  - diff_gt_q = abs > q.
  - diff_gt_s = abs > s.
- FSM states:
  - IDLE: if sum_gt_min → WAIT, clear timer. Otherwise stay.
  - WAIT: if sum_lt_min → IDLE (no rider_off). Else if diff_gt_q, clear timer and stay. Else if timer full → STEER_EN. Else timer increments.
  - STEER_EN: if sum_lt_min → IDLE and pulse rider_off. Else if diff_gt_s → WAIT, clear timer. Otherwise stay.
  - Illegal encoding (3) → IDLE next cycle, outputs low.
- Timer: TMR_W-bit counter; increments only in WAIT when not cleared; saturates at all-ones; "full" = all-ones.
- Priority when events coincide: sum_lt_min > diff check > timer full.

## Timing
- Reset values:
  - state IDLE, timer 0.
  - en_steer 0, rider_off 0, rider_state 0.
  - ld_cell_diff follows inputs even in reset.
- WAIT entry at cycle N: timer = 0 at N+1. Centred load held → timer full 2^TMR_W−1 cycles later; STEER_EN and en_steer=1 on the following edge.
- rider_off:
  - Asserted in the cycle rider_state first reads IDLE after STEER_EN.
  - Exactly one cycle wide.
  - Never asserted on WAIT→IDLE.
- en_steer deasserts on the same edge state leaves STEER_EN.
- Reset asserted mid-dwell or mid-steer: all outputs low asynchronously, no rider_off pulse.
- Input overflow is impossible: LD_W+1 result width.

## Configuration
- Macro `RIDER_HYST_EN`:
  - Defined: hysteresis as above.
  - Undefined: HYST ignored; sum_gt_min = sum ≥ MIN_WEIGHT and sum_lt_min = !sum_gt_min. This is single-threshold behaviour that chatters at the boundary.

## Test plan
Bench uses TMR_W=4 (dwell 15 cycles), other defaults.
- lft=rght=0x130 (sum 0x260) from IDLE → WAIT next edge; en_steer=1 exactly 16 edges after WAIT entry; rider_off stays 0.
- In WAIT, lft=0x200, rght=0x060 (abs 0x1A0 > q 0x098) pulsed at timer=10 → timer clears; en_steer delayed a full 15-cycle dwell after balance returns.
- In STEER_EN, drop to lft=rght=0xF0 (sum 0x1E0, inside band) → stays STEER_EN. Then lft=rght=0xD0 (sum 0x1A0) → IDLE, rider_off high one cycle, en_steer 0.
- In STEER_EN, lft=0x300, rght=0x000 (abs 0x300 > s 0x2D0) → WAIT, timer 0, en_steer 0, rider_off 0.
- Assert rst in STEER_EN → outputs 0 immediately, state IDLE; release → remains IDLE until sum > 0x240.
- Without `RIDER_HYST_EN`: sum toggling 0x1FF/0x200 each cycle → alternates IDLE/WAIT; with macro → remains IDLE.
